// File: rtl/alsu_result_buffer.sv
// Capture FIFO for ALSU results: tags each sample with an error bit and keeps sticky overflow/underflow flags and a saturating error count.
// Latency: a capture is visible in count one cycle later; rd_en gives registered dout one cycle later. Full drops pushes unless a pop happens in the same cycle.
// Optional ALSU_RB_DEDUP_EN: a capture equal to the previous capture is not pushed.
module alsu_result_buffer #(
    parameter int DEPTH     = 8,
    parameter int OUT_W     = 6,
    parameter int ERR_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OUT_W-1:0]         alsu_out,
    input  logic [15:0]              alsu_leds,
    input  logic                     capture_en,
    input  logic                     rd_en,
    output logic [OUT_W-1:0]         dout,
    output logic                     dout_err,
    output logic                     dout_vld,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    output logic [ERR_CNT_W-1:0]     err_count
);

    localparam int AW = $clog2(DEPTH);

    logic [OUT_W:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            sample_err;
    logic [OUT_W:0]  sample;
    logic            is_dup;
    logic            push_req;
    logic            do_push;
    logic            do_pop;
    logic [AW:0]     count_nxt;

    assign sample_err = (alsu_leds == 16'hFFFF);
    assign sample     = {sample_err, alsu_out};

`ifdef ALSU_RB_DEDUP_EN
    logic [OUT_W:0]  last_sample;
    logic            last_vld;

    // Dropped captures still update the reference sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_vld    <= 1'b0;
            last_sample <= '0;
        end else if (capture_en) begin
            last_vld    <= 1'b1;
            last_sample <= sample;
        end
    end

    assign is_dup = last_vld && (sample == last_sample);
`else
    assign is_dup = 1'b0;
`endif

    assign push_req = capture_en && !is_dup;
    assign do_pop   = rd_en && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts when rd_en is high.
    assign do_push  = push_req && (!full || rd_en);

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= sample;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            dout      <= '0;
            dout_err  <= 1'b0;
            dout_vld  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            err_count <= '0;
        end else begin
            count    <= count_nxt;
            empty    <= (count_nxt == '0);
            full     <= (count_nxt == (AW+1)'(DEPTH));
            dout_vld <= do_pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                dout     <= mem[rd_ptr][OUT_W-1:0];
                dout_err <= mem[rd_ptr][OUT_W];
            end
            if (push_req && full && !rd_en) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
            if (capture_en && sample_err && (err_count != {ERR_CNT_W{1'b1}})) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule
